mac_window_arbiter: RTL and testbench
=====================================

Name: mac_window_arbiter

Overview:
- Shares one matrixAccelerator (K×K multiply/accumulate engine) between NUM_REQ window producers, e.g. several Convolution_Controller line-buffer lanes.
- Arbitrates round-robin and latches the granted window's operands into the accelerator.
- Pulses the accelerator's start vector, waits for its accumulate result, and returns the sum to the granted requester over a valid/ready response.

Parameters:
- DATA_WIDTH, 32, width of each operand and of the accumulated sum.
- KERNEL_SIZE, 3, kernel edge length; a window holds KERNEL_SIZE*KERNEL_SIZE elements (KK).
- NUM_REQ, 4, number of requesters, 2..8.
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT (used only with ARB_TIMEOUT_EN).

Ports:
- Clk  in  1  single clock.
- Rst  in  1  reset: synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester window valid.
- req_ready  out  NUM_REQ  one-hot accept, asserted in LOAD only.
- req_multiplier  in  NUM_REQ*KK*DATA_WIDTH  flat data windows; requester r occupies slice r.
- req_multiplicand  in  NUM_REQ*KK*DATA_WIDTH  flat filter windows.
- rsp_valid  out  NUM_REQ  one-hot result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_sum  out  DATA_WIDTH  result, shared bus.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.
- busy  out  1  high in any state other than IDLE.
- multiplier_input  out  KK*DATA_WIDTH  to accelerator.
- multiplicand_input  out  KK*DATA_WIDTH  to accelerator.
- mStart  out  KK  to accelerator start vector.
- finalAccumulate  in  DATA_WIDTH  from accelerator.
- finalReady  in  1  from accelerator.

Behaviour:
- Reset (Rst high at a Clk edge):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - All outputs 0: req_ready, rsp_valid, rsp_err, mStart, busy, operand buses, rsp_sum.
  - finalReady edge register cleared.
  - Reset mid-transaction abandons the transaction silently: no response is issued and the accelerator is not stalled (its Rst is driven separately).
- FSM: IDLE -> LOAD -> START -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from rr_ptr and wrapping.
  - Register grant_id and go to LOAD.
  - If no req_valid is set, stay in IDLE.
- LOAD, one cycle:
  - req_ready[grant_id]=1.
  - Latch the granted slices into multiplier_input and multiplicand_input; they hold until the next LOAD.
  - The handshake completes unconditionally: a requester must keep valid asserted until ready.
- START, one cycle:
  - mStart = all ones for exactly one cycle, 0 otherwise.
- WAIT:
  - Detect a rising edge of finalReady (registered previous value; a level that was already high does not count).
  - On the edge, latch finalAccumulate into rsp_sum and go to RESP.
- RESP:
  - rsp_valid[grant_id]=1 while rsp_sum and rsp_err are held stable.
  - On rsp_ready[grant_id], drop rsp_valid, set rr_ptr=(grant_id+1) mod NUM_REQ, and go to IDLE.
  - rsp_ready of other indices is ignored.
- Latency: grant to mStart = 2 cycles. finalReady edge to rsp_valid = 1 cycle.
- Throughput: at most one outstanding transaction.
- Fairness:
  - A requester that keeps valid asserted waits at most NUM_REQ-1 transactions.
  - New req_valid arriving during a transaction is only considered in the next IDLE.
- Simultaneous requests in the same IDLE cycle: the round-robin order from rr_ptr decides.
- Arithmetic: no modification of operands or sum; sum width DATA_WIDTH (wraps as the accelerator does).

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT; if it reaches TIMEOUT_CYCLES without a finalReady edge, go to RESP with rsp_sum=0 and rsp_err=1.
  - The counter clears on entering WAIT.
  - A finalReady edge arriving in the same cycle as the timeout wins: normal result, err=0.
- ARB_TIMEOUT_EN undefined: WAIT waits indefinitely and rsp_err is constant 0.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=0, LOAD=1, START=2, WAIT=3, RESP=4, width 3.
  - KK constant and the clog2 helper for grant_id width.
- Sub-module: rr_arbiter, a combinational round-robin pick (req vector and pointer in, one-hot grant and index out), reusable for other shared resources.

Test Plan:
- Single request: req_valid=4'b0001 with window 1..9 and filter {1,0,...,0}; stub accelerator returns 1 after 5 cycles.
  -> mStart=9'h1FF exactly 2 cycles after grant; rsp_valid[0] with rsp_sum=1; busy falls after rsp_ready.
- All four requesters valid continuously.
  -> grant order 0,1,2,3,0,1; each rsp_sum matches its own window's dot product.
- finalReady already high on entry to WAIT.
  -> no completion until it goes low and rises again.
- rsp_ready held low for 10 cycles.
  -> rsp_valid and rsp_sum stable throughout; no new grant is issued.
- Rst pulsed during WAIT.
  -> next cycle all outputs 0, grant restarts from requester 0, and no stale rsp_valid follows the late finalReady.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a stub that never completes.
  -> rsp_valid after 16 WAIT cycles with rsp_err=1 and rsp_sum=0; without the macro, busy stays high.

Source files
------------

// File: rtl/mac_window_arbiter_pkg.sv
// Shared state encoding and sizing helpers for the MAC window arbiter.
package mac_window_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StStart = 3'd2,
    StWait  = 3'd3,
    StResp  = 3'd4
  } arb_state_e;

  // Elements per K x K window.
  function automatic int unsigned kk_of(input int unsigned kernel_size);
    return kernel_size * kernel_size;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_window_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping past N-1.
module mac_window_arbiter_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    logic [IdxW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_window_arbiter.sv
// Shares one K x K MAC accelerator between NUM_REQ window producers, round-robin.
// Define ARB_TIMEOUT_EN to add a WAIT-state watchdog that answers with rsp_err after
// TIMEOUT_CYCLES; without it TIMEOUT_CYCLES is unused and rsp_err stays 0.
module mac_window_arbiter
  import mac_window_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                                   Clk,
  input  logic                                                   Rst,
  input  logic [NUM_REQ-1:0]                                     req_valid,
  output logic [NUM_REQ-1:0]                                     req_ready,
  input  logic [NUM_REQ*kk_of(KERNEL_SIZE)*DATA_WIDTH-1:0]       req_multiplier,
  input  logic [NUM_REQ*kk_of(KERNEL_SIZE)*DATA_WIDTH-1:0]       req_multiplicand,
  output logic [NUM_REQ-1:0]                                     rsp_valid,
  input  logic [NUM_REQ-1:0]                                     rsp_ready,
  output logic [DATA_WIDTH-1:0]                                  rsp_sum,
  output logic                                                   rsp_err,
  output logic [idx_width(NUM_REQ)-1:0]                          grant_id,
  output logic                                                   busy,
  output logic [kk_of(KERNEL_SIZE)*DATA_WIDTH-1:0]               multiplier_input,
  output logic [kk_of(KERNEL_SIZE)*DATA_WIDTH-1:0]               multiplicand_input,
  output logic [kk_of(KERNEL_SIZE)-1:0]                          mStart,
  input  logic [DATA_WIDTH-1:0]                                  finalAccumulate,
  input  logic                                                   finalReady
);

  localparam int unsigned KK    = kk_of(KERNEL_SIZE);
  localparam int unsigned IdxW  = idx_width(NUM_REQ);
  localparam int unsigned WinW  = KK * DATA_WIDTH;
  localparam int unsigned BaseW = $clog2(NUM_REQ * WinW);

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [KK-1:0]       mstart_q, mstart_d;
  logic                busy_q, busy_d;
  logic [WinW-1:0]     mult_q, mult_d;
  logic [WinW-1:0]     mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic                rsp_err_q, rsp_err_d;
  logic                final_ready_q;
  logic                fr_edge;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_any;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [BaseW-1:0]    win_base;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  mac_window_arbiter_rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
  assign win_base     = BaseW'(grant_id_q) * BaseW'(WinW);
  // Only a low-to-high transition counts; a level already high on entry to WAIT is stale.
  assign fr_edge      = finalReady & ~final_ready_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    req_ready_d = '0;
    rsp_valid_d = rsp_valid_q;
    mstart_d    = '0;
    busy_d      = busy_q;
    mult_d      = mult_q;
    mcand_d     = mcand_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_err_d   = rsp_err_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d     = StLoad;
          grant_id_d  = arb_idx;
          req_ready_d = arb_gnt;
          busy_d      = 1'b1;
        end
      end
      StLoad: begin
        mult_d   = req_multiplier[win_base +: WinW];
        mcand_d  = req_multiplicand[win_base +: WinW];
        mstart_d = '1;
        state_d  = StStart;
      end
      StStart: begin
        state_d = StWait;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (fr_edge) begin
          rsp_sum_d   = finalAccumulate;
          rsp_err_d   = 1'b0;
          rsp_valid_d = grant_onehot;
          state_d     = StResp;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rsp_sum_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = grant_onehot;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (rsp_ready[grant_id_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (grant_id_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      mstart_q      <= '0;
      busy_q        <= 1'b0;
      mult_q        <= '0;
      mcand_q       <= '0;
      rsp_sum_q     <= '0;
      rsp_err_q     <= 1'b0;
      final_ready_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      mstart_q      <= mstart_d;
      busy_q        <= busy_d;
      mult_q        <= mult_d;
      mcand_q       <= mcand_d;
      rsp_sum_q     <= rsp_sum_d;
      rsp_err_q     <= rsp_err_d;
      final_ready_q <= finalReady;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_sum            = rsp_sum_q;
  assign rsp_err            = rsp_err_q;
  assign grant_id           = grant_id_q;
  assign busy               = busy_q;
  assign multiplier_input   = mult_q;
  assign multiplicand_input = mcand_q;
  assign mStart             = mstart_q;

endmodule

// File: tb/tb_mac_window_arbiter.sv
// Self-checking bench for mac_window_arbiter with a stub accelerator and a transaction model.
module tb_mac_window_arbiter;

  localparam int DW = 32;
  localparam int KS = 3;
  localparam int NR = 4;
  localparam int KK = 9;
  localparam int TO = 16;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*KK*DW-1:0] req_multiplier = '0;
  logic [NR*KK*DW-1:0] req_multiplicand = '0;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready = '0;
  logic [DW-1:0]     rsp_sum;
  logic              rsp_err;
  logic [1:0]        grant_id;
  logic              busy;
  logic [KK*DW-1:0]  multiplier_input;
  logic [KK*DW-1:0]  multiplicand_input;
  logic [KK-1:0]     mStart;
  logic [DW-1:0]     finalAccumulate;
  logic              finalReady;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mul_w [NR][KK];
  logic [DW-1:0] mc_w  [NR][KK];

  // Accelerator stub: manual drive or automatic dot product after stub_delay cycles.
  logic          manual  = 1'b0;
  logic          man_fr  = 1'b0;
  logic [DW-1:0] man_acc = '0;
  logic          auto_fr = 1'b0;
  logic [DW-1:0] auto_acc = '0;
  logic [DW-1:0] stub_acc = '0;
  logic          stub_busy = 1'b0;
  int            stub_cnt = 0;
  int            stub_delay = 5;

  assign finalReady      = manual ? man_fr : auto_fr;
  assign finalAccumulate = manual ? man_acc : auto_acc;

  mac_window_arbiter #(
    .DATA_WIDTH     (DW),
    .KERNEL_SIZE    (KS),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_multiplier     (req_multiplier),
    .req_multiplicand   (req_multiplicand),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_sum            (rsp_sum),
    .rsp_err            (rsp_err),
    .grant_id           (grant_id),
    .busy               (busy),
    .multiplier_input   (multiplier_input),
    .multiplicand_input (multiplicand_input),
    .mStart             (mStart),
    .finalAccumulate    (finalAccumulate),
    .finalReady         (finalReady)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] bus_dot();
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < KK; k++) s += multiplier_input[k*DW +: DW] * multiplicand_input[k*DW +: DW];
    return s;
  endfunction

  always @(negedge Clk) begin
    if (mStart == '1) begin
      stub_busy <= 1'b1;
      stub_cnt  <= stub_delay;
      stub_acc  <= bus_dot();
      auto_fr   <= 1'b0;
    end else if (stub_busy && stub_cnt <= 1) begin
      auto_fr   <= 1'b1;
      auto_acc  <= stub_acc;
      stub_busy <= 1'b0;
    end else begin
      auto_fr <= 1'b0;
      if (stub_busy) stub_cnt <= stub_cnt - 1;
    end
  end

  // Reference: dot product of the window the bench itself drove for requester r.
  function automatic logic [DW-1:0] dot(input int r);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < KK; k++) s += mul_w[r][k] * mc_w[r][k];
    return s;
  endfunction

  // Reference round-robin: first valid requester at or after p, wrapping.
  function automatic int pick(input logic [NR-1:0] m, input int p);
    for (int i = 0; i < NR; i++) if (m[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  task automatic pack();
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < KK; k++) begin
        req_multiplier[(r*KK + k)*DW +: DW]   = mul_w[r][k];
        req_multiplicand[(r*KK + k)*DW +: DW] = mc_w[r][k];
      end
    end
  endtask

  task automatic rand_windows();
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < KK; k++) begin
        mul_w[r][k] = $urandom;
        mc_w[r][k]  = (k % 2 == 0) ? DW'($urandom_range(0, 1000)) : $urandom;
      end
    end
    pack();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // One full transaction with the auto stub; caller has already driven req_valid.
  task automatic txn(input int id, input logic [DW-1:0] exp_sum, input int hold,
                     input logic [NR-1:0] valid_after);
    int n;
    logic [DW-1:0] sum0;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("req_ready", 64'(req_ready), 64'(1) << id);
    check("grant_id", 64'(grant_id), 64'(id));
    check("mstart_in_load", 64'(mStart), 64'(0));
    @(negedge Clk);
    check("mstart_pulse", 64'(mStart), 64'(9'h1FF));
    check("req_ready_after_load", 64'(req_ready), 64'(0));
    @(negedge Clk);
    check("mstart_one_cycle", 64'(mStart), 64'(0));
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("rsp_valid", 64'(rsp_valid), 64'(1) << id);
    check("rsp_sum", 64'(rsp_sum), 64'(exp_sum));
    check("rsp_err", 64'(rsp_err), 64'(0));
    sum0 = rsp_sum;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~(NR'(1) << id);
      @(negedge Clk);
      check("hold_valid", 64'(rsp_valid), 64'(1) << id);
      check("hold_sum", 64'(rsp_sum), 64'(sum0));
      check("hold_no_grant", 64'(req_ready), 64'(0));
    end
    rsp_ready = NR'(1) << id;
    req_valid = valid_after;
    @(negedge Clk);
    rsp_ready = '0;
    check("busy_low", 64'(busy), 64'(0));
    check("rsp_valid_low", 64'(rsp_valid), 64'(0));
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    int            id;
    int            hold;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int id;
    int ptr_m;
    logic [NR-1:0] cur_mask, nxt_mask;

    tbl[0]  = '{4'b1111, 0, 0};
    tbl[1]  = '{4'b1111, 1, 0};
    tbl[2]  = '{4'b1111, 2, 10};
    tbl[3]  = '{4'b1111, 3, 0};
    tbl[4]  = '{4'b1111, 0, 0};
    tbl[5]  = '{4'b1111, 1, 0};
    tbl[6]  = '{4'b0001, 0, 0};
    tbl[7]  = '{4'b1010, 1, 0};
    tbl[8]  = '{4'b1010, 3, 0};
    tbl[9]  = '{4'b0110, 1, 0};
    tbl[10] = '{4'b0110, 2, 0};
    tbl[11] = '{4'b0101, 0, 0};
    tbl[12] = '{4'b1000, 3, 0};

    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < KK; k++) begin
        mul_w[r][k] = '0;
        mc_w[r][k]  = '0;
      end
    end

    // Reset state.
    do_reset();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_mstart", 64'(mStart), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mult", 64'(|multiplier_input), 64'(0));
    check("rst_mcand", 64'(|multiplicand_input), 64'(0));
    check("rst_sum", 64'(rsp_sum), 64'(0));
    check("rst_grant", 64'(grant_id), 64'(0));

    // Single request: window 1..9, filter {1,0,...}, stub answers after 5 cycles.
    for (int k = 0; k < KK; k++) begin
      mul_w[0][k] = DW'(k + 1);
      mc_w[0][k]  = (k == 0) ? 32'd1 : 32'd0;
    end
    pack();
    stub_delay = 5;
    req_valid  = 4'b0001;
    @(negedge Clk);
    check("single_grant_latency", 64'(req_ready), 64'(1));
    check("single_busy", 64'(busy), 64'(1));
    txn(0, 32'd1, 0, 4'b0000);

    // Table: continuous all-valid order, then mixed masks from the carried pointer.
    do_reset();
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < KK; k++) begin
        mul_w[r][k] = DW'(r * 10 + k + 1);
        mc_w[r][k]  = DW'((k % 3) + r + 1);
      end
    end
    pack();
    stub_delay = 3;
    req_valid  = tbl[0].mask;
    for (int i = 0; i < 13; i++) begin
      txn(tbl[i].id, dot(tbl[i].id), tbl[i].hold, (i < 12) ? tbl[i+1].mask : 4'b0000);
    end

    // finalReady already high on entry to WAIT must not complete the transaction.
    manual    = 1'b1;
    man_fr    = 1'b1;
    man_acc   = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    @(negedge Clk);
    check("hi_grant", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;
    @(negedge Clk);
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("hi_no_done", 64'(rsp_valid), 64'(0));
      check("hi_busy", 64'(busy), 64'(1));
    end
    man_fr = 1'b0;
    @(negedge Clk);
    check("hi_low_no_done", 64'(rsp_valid), 64'(0));
    man_fr = 1'b1;
    @(negedge Clk);
    check("hi_edge_valid", 64'(rsp_valid), 64'(4'b0100));
    check("hi_edge_sum", 64'(rsp_sum), 64'(32'hDEAD_BEEF));
    rsp_ready = 4'b0100;
    @(negedge Clk);
    rsp_ready = '0;
    man_fr    = 1'b0;
    check("hi_busy_low", 64'(busy), 64'(0));

    // Reset during WAIT: silent abandon, pointer back to 0.
    req_valid = 4'b1111;
    @(negedge Clk);
    check("rw_grant", 64'(req_ready), 64'(4'b1000));
    @(negedge Clk);
    @(negedge Clk);
    req_valid = '0;
    Rst       = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("rw_busy", 64'(busy), 64'(0));
    check("rw_grant_id", 64'(grant_id), 64'(0));
    check("rw_mstart", 64'(mStart), 64'(0));
    check("rw_mult", 64'(|multiplier_input), 64'(0));
    check("rw_sum", 64'(rsp_sum), 64'(0));
    man_fr  = 1'b1;
    man_acc = 32'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("rw_no_stale_rsp", 64'(rsp_valid), 64'(0));
    end
    man_fr    = 1'b0;
    manual    = 1'b0;
    req_valid = 4'b1111;
    @(negedge Clk);
    check("rw_restart_0", 64'(req_ready), 64'(4'b0001));
    txn(0, dot(0), 0, 4'b0000);

`ifdef ARB_TIMEOUT_EN
    // Watchdog fires after TO WAIT cycles; a same-cycle edge beats it.
    manual    = 1'b1;
    man_fr    = 1'b0;
    req_valid = 4'b0010;
    @(negedge Clk);
    check("to_grant", 64'(req_ready), 64'(4'b0010));
    req_valid = '0;
    @(negedge Clk);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (rsp_valid == '0 && n < 100);
    check("to_latency", 64'(n), 64'(TO + 1));
    check("to_valid", 64'(rsp_valid), 64'(4'b0010));
    check("to_err", 64'(rsp_err), 64'(1));
    check("to_sum", 64'(rsp_sum), 64'(0));
    rsp_ready = 4'b0010;
    @(negedge Clk);
    rsp_ready = '0;
    req_valid = 4'b0100;
    @(negedge Clk);
    check("race_grant", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;
    @(negedge Clk);
    for (int i = 1; i <= TO; i++) begin
      @(negedge Clk);
      if (i == TO) begin
        check("race_pending", 64'(rsp_valid), 64'(0));
        man_fr  = 1'b1;
        man_acc = 32'd77;
      end
    end
    @(negedge Clk);
    check("race_valid", 64'(rsp_valid), 64'(4'b0100));
    check("race_err", 64'(rsp_err), 64'(0));
    check("race_sum", 64'(rsp_sum), 64'(77));
    rsp_ready = 4'b0100;
    @(negedge Clk);
    rsp_ready = '0;
    man_fr    = 1'b0;
    manual    = 1'b0;
`else
    // Without the watchdog a silent accelerator keeps the arbiter busy.
    manual    = 1'b1;
    man_fr    = 1'b0;
    req_valid = 4'b0010;
    @(negedge Clk);
    check("nto_grant", 64'(req_ready), 64'(4'b0010));
    req_valid = '0;
    for (int i = 0; i < 40; i++) @(negedge Clk);
    check("nto_busy", 64'(busy), 64'(1));
    check("nto_no_rsp", 64'(rsp_valid), 64'(0));
    check("nto_err", 64'(rsp_err), 64'(0));
    manual = 1'b0;
`endif

    // Randomised traffic against the round-robin / dot-product model.
    do_reset();
    ptr_m    = 0;
    cur_mask = NR'($urandom_range(1, 15));
    rand_windows();
    req_valid = cur_mask;
    for (int t = 0; t < 30; t++) begin
      id         = pick(cur_mask, ptr_m);
      nxt_mask   = (t == 29) ? 4'b0000 : NR'($urandom_range(1, 15));
      stub_delay = $urandom_range(1, 8);
      txn(id, dot(id), (t % 7 == 3) ? 2 : 0, nxt_mask);
      ptr_m    = (id + 1) % NR;
      cur_mask = nxt_mask;
      rand_windows();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
